// File: rtl/fp8_vector_mul_pipe.sv
// fp8_vector_mul_pipe: 3-stage elastic FP8 (E4M3/E5M2) scalar-by-vector multiply producing exact FP16 lanes
// Ports: clk, rst (async, active-high); e5m2mode/q/vec offered with in_valid/in_ready;
//        res/out_ovf/out_unf presented with out_valid/out_ready.
// Define FP8_MUL_SAT_EN to return +-65504 on finite overflow instead of signed Inf.
module fp8_vector_mul_pipe #(
  parameter int LANES = 4,
  parameter int OUT_REG_ONLY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  e5m2mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            q,
  input  logic [8*LANES-1:0]    vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*LANES-1:0]   res,
  output logic [LANES-1:0]      out_ovf,
  output logic [LANES-1:0]      out_unf
);
  typedef struct packed {
    logic       s;
    logic       nan;
    logic       inf;
    logic       zero;
    logic [5:0] e;
    logic [3:0] m;
  } dec_t;
  typedef struct packed {
    logic       s;
    logic [1:0] cls;
    logic [7:0] p;
    logic [6:0] e;
  } mul_t;
  localparam logic [1:0] C_NUM = 2'd0, C_NAN = 2'd1, C_INF = 2'd2, C_ZERO = 2'd3;
`ifdef FP8_MUL_SAT_EN
  localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
  localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif
  // Unbiased exponent (two's complement, 6 bits) and 1.xxx significand; subnormals normalised here.
  function automatic dec_t dec(input logic [7:0] x, input logic m5);
    logic [4:0] ef;
    logic [2:0] mf;
    logic [5:0] eb;
    dec_t r;
    ef = m5 ? x[6:2] : {1'b0, x[6:3]};
    mf = m5 ? {x[1:0], 1'b0} : x[2:0];
    eb = m5 ? 6'd15 : 6'd7;
    r.s = x[7];
    r.nan = m5 ? (&ef && |mf) : (ef == 5'd15 && &mf);
    r.inf = m5 && &ef && ~|mf;
    r.zero = ~|ef && ~|mf;
    r.e = |ef ? {1'b0, ef} - eb : mf[2] ? 6'd0 - eb : mf[1] ? 6'd63 - eb : 6'd62 - eb;
    r.m = |ef ? {1'b1, mf} : mf[2] ? {mf, 1'b0} : mf[1] ? {mf[1:0], 2'b0} : 4'b1000;
    return r;
  endfunction
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic en1, en2, en3;
  dec_t dq_q, dq_d;
  dec_t [LANES-1:0] dv_q, dv_d;
  mul_t [LANES-1:0] m_q, m_d;
  logic [16*LANES-1:0] res_q, res_d;
  logic [LANES-1:0] ovf_q, ovf_d, unf_q, unf_d;
  always_comb begin
    en3 = !v3_q || out_ready;
    en2 = OUT_REG_ONLY != 0 ? en3 : !v2_q || en3;
    en1 = OUT_REG_ONLY != 0 ? en3 : !v1_q || en2;
    v1_d = en1 ? in_valid : v1_q;
    v2_d = en2 ? v1_q : v2_q;
    v3_d = en3 ? v2_q : v3_q;
    dq_d = dec(q, e5m2mode);
    for (int i = 0; i < LANES; i++) begin
      dv_d[i] = dec(vec[8*i +: 8], e5m2mode);
      m_d[i].s = dq_q.s ^ dv_q[i].s;
      m_d[i].cls = (dq_q.nan || dv_q[i].nan || (dq_q.inf && dv_q[i].zero) || (dq_q.zero && dv_q[i].inf)) ? C_NAN :
                   (dq_q.inf || dv_q[i].inf) ? C_INF :
                   (dq_q.zero || dv_q[i].zero) ? C_ZERO : C_NUM;
      m_d[i].p = {4'b0, dq_q.m} * {4'b0, dv_q[i].m};
      m_d[i].e = {dq_q.e[5], dq_q.e} + {dv_q[i].e[5], dv_q[i].e} + 7'd15 + {6'b0, m_d[i].p[7]};
      ovf_d[i] = m_q[i].cls == C_NUM && $signed(m_q[i].e) > 7'sd30;
      unf_d[i] = m_q[i].cls == C_NUM && $signed(m_q[i].e) < 7'sd1;
      res_d[16*i +: 16] = m_q[i].cls == C_NAN ? 16'h7E00 :
                          m_q[i].cls == C_INF ? {m_q[i].s, 15'h7C00} :
                          m_q[i].cls == C_ZERO ? {m_q[i].s, 15'h0} :
                          ovf_d[i] ? {m_q[i].s, OVF_MAG} :
                          unf_d[i] ? {m_q[i].s, 15'h0} :
                          m_q[i].p[7] ? {m_q[i].s, m_q[i].e[4:0], m_q[i].p[6:0], 3'b0} :
                                        {m_q[i].s, m_q[i].e[4:0], m_q[i].p[5:0], 4'b0};
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      dq_q <= '0;
      dv_q <= '0;
      m_q <= '0;
      res_q <= '0;
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (en1 && in_valid) begin
        dq_q <= dq_d;
        dv_q <= dv_d;
      end
      if (en2 && v1_q) m_q <= m_d;
      if (en3 && v2_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end
  assign in_ready = en1;
  assign out_valid = v3_q;
  assign res = res_q;
  assign out_ovf = ovf_q;
  assign out_unf = unf_q;
endmodule

// File: tb/tb_fp8_vector_mul_pipe.sv
// tb_fp8_vector_mul_pipe: scoreboard bench for fp8_vector_mul_pipe against a real-arithmetic reference model
module tb_fp8_vector_mul_pipe;
  localparam int L = 4;
  logic clk = 0;
  logic rst = 1;
  logic e5m2mode = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [7:0] q = 0;
  logic [8*L-1:0] vec = 0;
  logic out_valid;
  logic out_ready = 1;
  logic [16*L-1:0] res;
  logic [L-1:0] out_ovf, out_unf;

  fp8_vector_mul_pipe #(.LANES(L), .OUT_REG_ONLY(0)) dut (
    .clk(clk), .rst(rst), .e5m2mode(e5m2mode), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .vec(vec), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .out_ovf(out_ovf), .out_unf(out_unf));

  always #5 clk = ~clk;

  typedef struct {
    logic [16*L-1:0] r;
    logic [L-1:0]    o;
    logic [L-1:0]    u;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  bit rnd = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    for (int i = 0; i < n; i++) r = r * 2.0;
    for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  // Magnitude of a finite FP8 value.
  function automatic real fp8r(input logic [7:0] x, input bit m5);
    int e, m;
    if (m5) begin
      e = int'(x[6:2]); m = int'(x[1:0]);
      return e == 0 ? (m / 4.0) * pow2(-14) : (1.0 + m / 4.0) * pow2(e - 15);
    end
    e = int'(x[6:3]); m = int'(x[2:0]);
    return e == 0 ? (m / 8.0) * pow2(-6) : (1.0 + m / 8.0) * pow2(e - 7);
  endfunction

  function automatic logic [14:0] enc16(input real a);
    int e = 0;
    real m = a;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {5'(e + 15), 10'($rtoi((m - 1.0) * 1024.0))};
  endfunction

  function automatic exp_t model(input logic [7:0] qa, input logic [8*L-1:0] va, input bit m5);
    exp_t x;
    logic [7:0] b;
    logic s;
    bit nq, nb, iq, ib, zq, zb;
    real a;
    x.o = '0; x.u = '0; x.r = '0;
    nq = m5 ? (qa[6:2] == 5'd31 && qa[1:0] != 0) : (qa[6:0] == 7'h7F);
    iq = m5 && qa[6:0] == 7'h7C;
    zq = qa[6:0] == 0;
    for (int i = 0; i < L; i++) begin
      b = va[8*i +: 8];
      s = qa[7] ^ b[7];
      nb = m5 ? (b[6:2] == 5'd31 && b[1:0] != 0) : (b[6:0] == 7'h7F);
      ib = m5 && b[6:0] == 7'h7C;
      zb = b[6:0] == 0;
      if (nq || nb || (iq && zb) || (zq && ib)) x.r[16*i +: 16] = 16'h7E00;
      else if (iq || ib) x.r[16*i +: 16] = {s, 15'h7C00};
      else if (zq || zb) x.r[16*i +: 16] = {s, 15'h0};
      else begin
        a = fp8r(qa, m5) * fp8r(b, m5);
        if (a >= 65536.0) begin
          x.o[i] = 1'b1;
`ifdef FP8_MUL_SAT_EN
          x.r[16*i +: 16] = {s, 15'h7BFF};
`else
          x.r[16*i +: 16] = {s, 15'h7C00};
`endif
        end else if (a < pow2(-14)) begin
          x.u[i] = 1'b1;
          x.r[16*i +: 16] = {s, 15'h0};
        end else x.r[16*i +: 16] = {s, enc16(a)};
      end
    end
    return x;
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks holds during stalls.
  bit prev_stall = 0;
  logic [16*L-1:0] prev_res;
  logic [L-1:0] prev_o, prev_u;
  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_res", res, prev_res);
        chk("stall_flags", {out_ovf, out_unf}, {prev_o, prev_u});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got res %h with empty scoreboard at %0t", res, $time);
        end else begin
          e = sb.pop_front();
          chk("res", res, e.r);
          chk("ovf", 64'(out_ovf), 64'(e.o));
          chk("unf", 64'(out_unf), 64'(e.u));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res = res; prev_o = out_ovf; prev_u = out_unf;
    end
  end

  task automatic send(input logic [7:0] qa, input logic [8*L-1:0] va, input bit m5);
    in_valid = 1; q = qa; vec = va; e5m2mode = m5;
    for (int n = 0; n < 100; n++) begin
      if (rnd) out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(qa, va, m5));
        @(posedge clk); #1;
        in_valid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    $display("FAIL accept_timeout: in_ready stayed 0 for 100 cycles at %0t", $time);
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    for (int n = 0; n < 200 && sb.size() != 0; n++) begin @(posedge clk); #1; end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  logic [7:0] bq[5];
  logic [8*L-1:0] bv[5];
  bit bm[5];
  int idx, stale;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_res", res, 64'd0);
    chk("rst_flags", {out_ovf, out_unf}, 8'h00);
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    // directed cases
    send(8'h3C, 32'hC840C43C, 0);
    send(8'h7E, 32'h00007F7E, 0);
    send(8'h3C, 32'h017C0040, 1);
    send(8'h01, 32'h01010101, 1);
    send(8'h7C, 32'h80808080, 1);
    send(8'h00, 32'h80808080, 0);
    send(8'hBC, 32'hFB7B0A88, 0);
    drain();
    // randomized traffic with random back-pressure
    rnd = 1;
    repeat (300) begin
      send(8'($urandom), 32'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        out_ready = $urandom_range(0, 1) != 0;
        @(posedge clk); #1;
      end
    end
    rnd = 0;
    drain();
    // back-pressure burst: 5 offered, only 3 fit
    for (int i = 0; i < 5; i++) begin bq[i] = 8'($urandom); bv[i] = 32'($urandom); bm[i] = 1'($urandom); end
    out_ready = 0; idx = 0;
    repeat (8) begin
      in_valid = 1; q = bq[idx]; vec = bv[idx]; e5m2mode = bm[idx];
      @(negedge clk);
      if (in_ready) begin sb.push_back(model(bq[idx], bv[idx], bm[idx])); idx++; end
      @(posedge clk); #1;
    end
    chk("burst_accepts", 64'(idx), 64'd3);
    chk("burst_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1;
    for (int n = 0; n < 20 && idx < 5; n++) begin
      in_valid = 1; q = bq[idx]; vec = bv[idx]; e5m2mode = bm[idx];
      @(negedge clk);
      if (in_ready) begin sb.push_back(model(bq[idx], bv[idx], bm[idx])); idx++; end
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("burst_total", 64'(idx), 64'd5);
    drain();
    // reset with the pipe full
    out_ready = 0;
    send(8'h3C, 32'h3C3C3C3C, 0);
    send(8'h40, 32'h40404040, 0);
    send(8'h44, 32'h44444444, 1);
    @(posedge clk); #1;
    chk("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_res", res, 64'd0);
    sb.delete();
    @(posedge clk); #2;
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1; stale = 0;
    repeat (6) begin @(negedge clk); if (out_valid) stale++; end
    chk("no_stale", 64'(stale), 64'd0);
    // traffic resumes after reset
    send(8'h3C, 32'hC840C43C, 0);
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
